// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU pipeline control blocks: controller states,
// zero-mux select values and the bundle of stage-control outputs.
package cpu_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } ctrl_state_e;

  localparam logic ZSEL_PASS   = 1'b0;
  localparam logic ZSEL_BUBBLE = 1'b1;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_zsel;
    logic id_ex_zsel;
  } ctrl_out_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and asynchronous active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up to all-ones and hold there; never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_bubble_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash, memory-busy
// freeze, bubble counting and sticky memory timeout detection.
module pipeline_bubble_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_busy,
  input  logic                  i_count_clear,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_id_ex_write,
  output logic                  o_ex_mem_write,
  output logic                  o_if_id_zero_sel,
  output logic                  o_id_ex_zero_sel,
  output logic [CNT_W-1:0]      o_bubble_count,
  output logic                  o_mem_timeout
);

  localparam logic [3:0] FLUSH_INIT = 4'(BRANCH_PENALTY - 1);
  localparam bit         HAS_FLUSH  = (BRANCH_PENALTY > 1);
  localparam logic [7:0] TO_LAST    = 8'(MEM_TIMEOUT - 1);

  ctrl_state_e r_state;
  ctrl_state_e r_ret_state;
  ctrl_state_e w_eff_state;
  logic [3:0]  r_flush_rem;
  logic        r_mem_timeout;
  logic        w_load_use;
  logic        w_bubble;
  logic [7:0]  w_wait_cnt;
  ctrl_out_t   w_out;

  assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));

  // The cycle memory frees up already behaves as the state WAIT interrupted.
  assign w_eff_state = (r_state == ST_WAIT) ? r_ret_state : r_state;

  // Stage enable / zero-mux decode from effective state and live inputs.
  always_comb begin
    w_out = '0;
    if (!rst_n) begin
      w_out.if_id_zsel = ZSEL_BUBBLE;
      w_out.id_ex_zsel = ZSEL_BUBBLE;
    end else if (i_mem_busy) begin
      w_out = '0;
    end else begin
      w_out.pc_write     = 1'b1;
      w_out.if_id_write  = 1'b1;
      w_out.id_ex_write  = 1'b1;
      w_out.ex_mem_write = 1'b1;
      case (w_eff_state)
        ST_FLUSH: begin
          w_out.if_id_zsel = ZSEL_BUBBLE;
          w_out.id_ex_zsel = ZSEL_PASS;
        end
        ST_RUN: begin
          if (i_branch_taken) begin
            w_out.if_id_zsel = ZSEL_BUBBLE;
            w_out.id_ex_zsel = ZSEL_BUBBLE;
          end else if (w_load_use) begin
            w_out.pc_write    = 1'b0;
            w_out.if_id_write = 1'b0;
            w_out.if_id_zsel  = ZSEL_PASS;
            w_out.id_ex_zsel  = ZSEL_BUBBLE;
          end else begin
            w_out.if_id_zsel = ZSEL_PASS;
            w_out.id_ex_zsel = ZSEL_PASS;
          end
        end
        default: w_out = '0;
      endcase
    end
  end

  // Controller state: WAIT remembers where to resume, FLUSH counts down squashes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_flush_rem <= 4'd0;
    end else if (i_mem_busy) begin
      r_state     <= ST_WAIT;
      r_ret_state <= w_eff_state;
    end else begin
      case (w_eff_state)
        ST_FLUSH: begin
          if (r_flush_rem <= 4'd1) begin
            r_state     <= ST_RUN;
            r_flush_rem <= 4'd0;
          end else begin
            r_state     <= ST_FLUSH;
            r_flush_rem <= r_flush_rem - 4'd1;
          end
        end
        ST_RUN: begin
          if (i_branch_taken && HAS_FLUSH) begin
            r_state     <= ST_FLUSH;
            r_flush_rem <= FLUSH_INIT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign w_bubble = (w_out.if_id_zsel || w_out.id_ex_zsel) && !i_mem_busy;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_bubble),
    .i_clr  (i_count_clear),
    .o_count(o_bubble_count)
  );

  sat_counter #(.W(8)) u_wait_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (i_mem_busy),
    .i_clr  (!i_mem_busy),
    .o_count(w_wait_cnt)
  );

  // Sticky timeout: sets on the busy cycle that brings the wait count to the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_timeout <= 1'b0;
    end else if (i_count_clear) begin
      r_mem_timeout <= 1'b0;
    end else if (i_mem_busy && (w_wait_cnt >= TO_LAST)) begin
      r_mem_timeout <= 1'b1;
    end else begin
      r_mem_timeout <= r_mem_timeout;
    end
  end

  assign o_pc_write       = w_out.pc_write;
  assign o_if_id_write    = w_out.if_id_write;
  assign o_id_ex_write    = w_out.id_ex_write;
  assign o_ex_mem_write   = w_out.ex_mem_write;
  assign o_if_id_zero_sel = w_out.if_id_zsel;
  assign o_id_ex_zero_sel = w_out.id_ex_zsel;
  assign o_mem_timeout    = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_bubble_ctrl.sv
// Bench for pipeline_bubble_ctrl: vector table, hand sequences for multi-cycle
// corners, and random stimulus against a countdown-based reference model.
module tb_pipeline_bubble_ctrl;

  localparam int AW = 3;
  localparam int BP = 2;
  localparam int MT = 255;
  localparam int CW = 16;

  localparam logic [5:0] O_NORM = 6'b111100;
  localparam logic [5:0] O_LU   = 6'b001101;
  localparam logic [5:0] O_BR   = 6'b111111;
  localparam logic [5:0] O_FL   = 6'b111110;
  localparam logic [5:0] O_FRZ  = 6'b000000;
  localparam logic [5:0] O_RST  = 6'b000011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic uses_rt = 1'b0, ex_mem_read = 1'b0, br = 1'b0, busy = 1'b0, clr = 1'b0;
  logic pcw, ifw, idw, exw, ifz, idz, to;
  logic [CW-1:0] bub;

  int n_cmp = 0;
  int n_bad = 0;
  int m_flush = 0;
  int m_bub = 0;
  int m_wait = 0;
  int m_to = 0;

  always #5 clk = ~clk;

  pipeline_bubble_ctrl #(
    .REG_ADDR_W(AW), .BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd),
    .i_branch_taken(br), .i_mem_busy(busy), .i_count_clear(clr),
    .o_pc_write(pcw), .o_if_id_write(ifw), .o_id_ex_write(idw), .o_ex_mem_write(exw),
    .o_if_id_zero_sel(ifz), .o_id_ex_zero_sel(idz),
    .o_bubble_count(bub), .o_mem_timeout(to)
  );

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urt;
    logic          emr;
    logic [AW-1:0] rd;
    logic          br;
    logic          busy;
    logic          clr;
  } vin_t;

  typedef struct {
    string      nm;
    vin_t       in;
    logic [5:0] exp;
  } vec_t;

  function automatic vin_t mk(int rs, int rt, int urt, int emr, int rd, int b, int bz, int c);
    vin_t v;
    v.rs   = AW'(rs);
    v.rt   = AW'(rt);
    v.urt  = urt[0];
    v.emr  = emr[0];
    v.rd   = AW'(rd);
    v.br   = b[0];
    v.busy = bz[0];
    v.clr  = c[0];
    return v;
  endfunction

  task automatic drive(input vin_t v);
    id_rs = v.rs; id_rt = v.rt; uses_rt = v.urt; ex_mem_read = v.emr;
    ex_rd = v.rd; br = v.br; busy = v.busy; clr = v.clr;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: a pending-squash countdown; memory busy simply freezes time.
  function automatic logic [5:0] model_out();
    bit lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((ex_rd == id_rs) || (uses_rt && (ex_rd == id_rt)));
    if (busy) return O_FRZ;
    if (m_flush > 0) return O_FL;
    if (br) return O_BR;
    if (lu) return O_LU;
    return O_NORM;
  endfunction

  task automatic model_step();
    logic [5:0] o;
    o = model_out();
    if (!busy) begin
      if (m_flush > 0) m_flush--;
      else if (br) m_flush = BP - 1;
    end
    if (busy) begin
      m_wait = (m_wait < 255) ? m_wait + 1 : 255;
      if (m_wait >= MT) m_to = 1;
    end else begin
      m_wait = 0;
    end
    if (!busy && (o[1] || o[0])) m_bub = (m_bub < 65535) ? m_bub + 1 : 65535;
    if (clr) begin
      m_bub = 0;
      m_to  = 0;
    end
  endtask

  task automatic step(input vin_t v, input string nm, input bit use_model, input logic [5:0] exp);
    logic [5:0] e;
    drive(v);
    #2;
    e = use_model ? model_out() : exp;
    chk({nm, "/outs"}, int'({pcw, ifw, idw, exw, ifz, idz}), int'(e));
    chk({nm, "/bubbles"}, int'(bub), m_bub);
    chk({nm, "/timeout"}, int'(to), m_to);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string nm);
    rst_n = 1'b0;
    drive(mk(7, 7, 1, 1, 7, 1, 1, 1));
    #2;
    chk({nm, "/outs"}, int'({pcw, ifw, idw, exw, ifz, idz}), int'(O_RST));
    chk({nm, "/bubbles"}, int'(bub), 0);
    chk({nm, "/timeout"}, int'(to), 0);
    m_flush = 0; m_bub = 0; m_wait = 0; m_to = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  vec_t tbl[8];
  vin_t idle;
  vin_t bz;
  int   b0;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    bz   = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[0] = '{"normal",      mk(1, 2, 1, 0, 1, 0, 0, 0), O_NORM};
    tbl[1] = '{"lu_rs",       mk(3, 0, 0, 1, 3, 0, 0, 0), O_LU};
    tbl[2] = '{"lu_rt",       mk(1, 5, 1, 1, 5, 0, 0, 0), O_LU};
    tbl[3] = '{"rd_zero",     mk(0, 0, 1, 1, 0, 0, 0, 0), O_NORM};
    tbl[4] = '{"rt_unused",   mk(1, 4, 0, 1, 4, 0, 0, 0), O_NORM};
    tbl[5] = '{"not_load",    mk(2, 0, 0, 0, 2, 0, 0, 0), O_NORM};
    tbl[6] = '{"busy_lu",     mk(3, 0, 0, 1, 3, 0, 1, 0), O_FRZ};
    tbl[7] = '{"after_busy",  mk(1, 2, 1, 0, 6, 0, 0, 0), O_NORM};

    reset_check("reset");
    step(idle, "release", 1'b0, O_NORM);

    step(mk(3, 0, 0, 1, 3, 0, 0, 0), "lu_first", 1'b0, O_LU);
    chk("lu_count", int'(bub), 1);

    for (int i = 0; i < 8; i++) step(tbl[i].in, tbl[i].nm, 1'b0, tbl[i].exp);

    b0 = m_bub;
    step(mk(0, 0, 0, 0, 0, 1, 0, 0), "branch", 1'b0, O_BR);
    step(idle, "flush1", 1'b0, O_FL);
    step(idle, "flush_done", 1'b0, O_NORM);
    chk("branch_bubbles", int'(bub), b0 + 2);

    step(mk(3, 0, 0, 1, 3, 1, 0, 0), "br_and_lu", 1'b0, O_BR);
    for (int i = 0; i < 3; i++) step(mk(3, 0, 0, 1, 3, 1, 1, 0), "busy_in_flush", 1'b0, O_FRZ);
    step(mk(3, 0, 0, 1, 3, 1, 0, 0), "flush_resume", 1'b0, O_FL);
    step(idle, "flush_resume_done", 1'b0, O_NORM);

    step(mk(0, 0, 0, 0, 0, 1, 0, 0), "branch_pre_rst", 1'b0, O_BR);
    reset_check("reset_in_flush");
    step(idle, "no_residual_flush", 1'b0, O_NORM);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0), "branch_pre_wait", 1'b0, O_BR);
    step(bz, "wait_pre_rst", 1'b0, O_FRZ);
    reset_check("reset_in_wait");
    step(idle, "no_residual_wait", 1'b0, O_NORM);
    step(idle, "no_residual_wait2", 1'b0, O_NORM);

    for (int i = 0; i < MT; i++) step(bz, "busy_long", 1'b1, O_FRZ);
    chk("timeout_at_limit", int'(to), 1);
    step(idle, "timeout_sticky", 1'b0, O_NORM);
    step(mk(3, 0, 0, 1, 3, 0, 0, 1), "clear_vs_lu", 1'b0, O_LU);
    chk("clear_timeout", int'(to), 0);
    chk("clear_bubbles", int'(bub), 0);

    for (int i = 0; i < 400; i++) begin
      vin_t v;
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 29) == 0));
      step(v, "rand", 1'b1, O_FRZ);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
